// File: rtl/fetch_pair_unit.sv
// fetch_pair_unit
//   Dual-issue fetch front end. Drives the instruction_mem fetch-address pair
//   and captures the returned instruction pair into a circular queue. The
//   queue presents its two oldest entries to decode.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   pc_o, pc4_o       fetch addresses of slot A / slot B (pc4_o = pc_o + 4)
//   instr1_i/instr2_i instructions at pc_o / pc4_o, same cycle as the address
//   redirect_i        flush queue and restart fetch at redirect_pc_i (word aligned)
//   deq_cnt_i         entries retired by decode this cycle (3 behaves as 2)
//   q_count_o         queue occupancy
//   slot0_* / slot1_* head and head+1 entries (valid, instruction, PC)
module fetch_pair_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [63:0]              pc_o,
    output logic [63:0]              pc4_o,
    input  logic [31:0]              instr1_i,
    input  logic [31:0]              instr2_i,
    input  logic                     redirect_i,
    input  logic [63:0]              redirect_pc_i,
    input  logic [1:0]               deq_cnt_i,
    output logic [$clog2(QDEPTH):0]  q_count_o,
    output logic                     slot0_valid_o,
    output logic [31:0]              slot0_instr_o,
    output logic [63:0]              slot0_pc_o,
    output logic                     slot1_valid_o,
    output logic [31:0]              slot1_instr_o,
    output logic [63:0]              slot1_pc_o
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [63:0]   r_pc;

    logic [31:0]   r_qinstr [QDEPTH];
    logic [63:0]   r_qpc    [QDEPTH];

    logic [1:0]    w_deq_req;
    logic [CW-1:0] w_deq_ext;
    logic [CW-1:0] w_eff;
    logic [CW-1:0] w_after;
    logic [CW:0]   w_need;
    logic          w_enq;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;

    // Free space is judged after this cycle's dequeue, so a full queue can
    // still accept a pair when decode retires two entries in the same cycle.
    always_comb begin
        w_deq_req = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
        w_deq_ext = CW'(w_deq_req);
        w_eff     = (w_deq_ext > r_count) ? r_count : w_deq_ext;
        w_after   = r_count - w_eff;
        w_need    = {1'b0, w_after} + (CW+1)'(2);
        w_enq     = !redirect_i && (w_need <= (CW+1)'(QDEPTH));
        w_head1   = r_head + AW'(1);
        w_tail1   = r_tail + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_pc    <= RESET_PC;
        end else if (redirect_i) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_pc    <= {redirect_pc_i[63:2], 2'b00};
        end else begin
            r_head <= r_head + AW'(w_eff);
            if (w_enq) begin
                r_count <= w_after + CW'(2);
                r_tail  <= r_tail + AW'(2);
                r_pc    <= r_pc + 64'd8;
            end else begin
                r_count <= w_after;
            end
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_qinstr[r_tail]  <= instr1_i;
            r_qpc[r_tail]     <= r_pc;
            r_qinstr[w_tail1] <= instr2_i;
            r_qpc[w_tail1]    <= r_pc + 64'd4;
        end
    end

    always_comb begin
        pc_o          = r_pc;
        pc4_o         = r_pc + 64'd4;
        q_count_o     = r_count;
        slot0_valid_o = (r_count >= CW'(1));
        slot1_valid_o = (r_count >= CW'(2));
        slot0_instr_o = slot0_valid_o ? r_qinstr[r_head]  : '0;
        slot0_pc_o    = slot0_valid_o ? r_qpc[r_head]     : '0;
        slot1_instr_o = slot1_valid_o ? r_qinstr[w_head1] : '0;
        slot1_pc_o    = slot1_valid_o ? r_qpc[w_head1]    : '0;
    end

endmodule

// File: tb/tb_fetch_pair_unit.sv
// tb_fetch_pair_unit
//   Directed bench for fetch_pair_unit. A queue-based reference model tracks
//   the expected fetch PC and buffered entries; a compare process checks all
//   outputs on every falling edge, and literal checks pin key points.
module tb_fetch_pair_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned QDEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_o, pc4_o;
    logic [31:0] instr1_i, instr2_i;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic [1:0]  deq_cnt_i = 2'd0;
    logic [2:0]  q_count_o;
    logic        slot0_valid_o, slot1_valid_o;
    logic [31:0] slot0_instr_o, slot1_instr_o;
    logic [63:0] slot0_pc_o, slot1_pc_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fetch_pair_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_o(pc_o), .pc4_o(pc4_o),
        .instr1_i(instr1_i), .instr2_i(instr2_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .deq_cnt_i(deq_cnt_i), .q_count_o(q_count_o),
        .slot0_valid_o(slot0_valid_o), .slot0_instr_o(slot0_instr_o), .slot0_pc_o(slot0_pc_o),
        .slot1_valid_o(slot1_valid_o), .slot1_instr_o(slot1_instr_o), .slot1_pc_o(slot1_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h015A04B3;
            64'h4:   return 32'h00148493;
            64'h8:   return 32'hF0953823;
            64'hC:   return 32'hF1053283;
            default: return a[31:0] ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign instr1_i = imem(pc_o);
    assign instr2_i = imem(pc4_o);

    // Reference model: expected fetch PC and queue of {instr, pc} entries.
    typedef struct { logic [31:0] instr; logic [63:0] pc; } entry_t;
    entry_t      mq[$];
    logic [63:0] mpc = RESET_PC;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (redirect_i) begin
            mq.delete();
            mpc = {redirect_pc_i[63:2], 2'b00};
        end else begin
            int req;
            int take;
            req  = (deq_cnt_i == 2'd3) ? 2 : int'(deq_cnt_i);
            take = (req < mq.size()) ? req : mq.size();
            repeat (take) void'(mq.pop_front());
            if (mq.size() + 2 <= QDEPTH) begin
                mq.push_back('{imem(mpc), mpc});
                mq.push_back('{imem(mpc + 64'd4), mpc + 64'd4});
                mpc = mpc + 64'd8;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", 64'(q_count_o), 64'(mq.size()));
            chk("pc", pc_o, mpc);
            chk("pc4", pc4_o, mpc + 64'd4);
            chk("s0v", 64'(slot0_valid_o), 64'(mq.size() >= 1));
            chk("s1v", 64'(slot1_valid_o), 64'(mq.size() >= 2));
            chk("s0i", 64'(slot0_instr_o), (mq.size() >= 1) ? 64'(mq[0].instr) : 64'd0);
            chk("s0pc", slot0_pc_o, (mq.size() >= 1) ? mq[0].pc : 64'd0);
            chk("s1i", 64'(slot1_instr_o), (mq.size() >= 2) ? 64'(mq[1].instr) : 64'd0);
            chk("s1pc", slot1_pc_o, (mq.size() >= 2) ? mq[1].pc : 64'd0);
            if (slot0_valid_o && slot1_valid_o)
                chk("order", slot1_pc_o, slot0_pc_o + 64'd4);
            chk("bound", 64'(q_count_o <= 3'(QDEPTH)), 64'd1);
        end
    end

    task automatic step(input logic [1:0] deq, input logic redir, input logic [63:0] rpc);
        deq_cnt_i     = deq;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #22;
        rst_n = 1'b1;
        #1;
        chk("rst_pc", pc_o, 64'h0);
        chk("rst_pc4", pc4_o, 64'h4);
        chk("rst_cnt", 64'(q_count_o), 64'd0);
        chk("rst_s0v", 64'(slot0_valid_o), 64'd0);
        chk("rst_s0i", 64'(slot0_instr_o), 64'd0);
        cmp_en = 1'b1;

        step(2'd0, 1'b0, '0);
        chk("f1_pc", pc_o, 64'h8);
        chk("f1_cnt", 64'(q_count_o), 64'd2);
        chk("f1_s0i", 64'(slot0_instr_o), 64'h015A04B3);
        chk("f1_s0pc", slot0_pc_o, 64'h0);
        chk("f1_s1i", 64'(slot1_instr_o), 64'h00148493);
        chk("f1_s1pc", slot1_pc_o, 64'h4);

        step(2'd0, 1'b0, '0);
        chk("f2_cnt", 64'(q_count_o), 64'd4);
        chk("f2_pc", pc_o, 64'h10);
        step(2'd0, 1'b0, '0);
        chk("stall_pc", pc_o, 64'h10);
        chk("stall_cnt", 64'(q_count_o), 64'd4);

        step(2'd2, 1'b0, '0);
        chk("full_cnt", 64'(q_count_o), 64'd4);
        chk("full_pc", pc_o, 64'h18);
        chk("full_s0pc", slot0_pc_o, 64'h8);
        chk("full_s0i", 64'(slot0_instr_o), 64'hF0953823);
        chk("full_s1pc", slot1_pc_o, 64'hC);
        chk("full_s1i", 64'(slot1_instr_o), 64'hF1053283);

        step(2'd1, 1'b0, '0);
        chk("c3_cnt", 64'(q_count_o), 64'd3);

        step(2'd2, 1'b1, 64'h25);
        chk("rd_cnt", 64'(q_count_o), 64'd0);
        chk("rd_s0v", 64'(slot0_valid_o), 64'd0);
        chk("rd_s1v", 64'(slot1_valid_o), 64'd0);
        chk("rd_pc", pc_o, 64'h24);
        chk("rd_pc4", pc4_o, 64'h28);
        step(2'd0, 1'b0, '0);
        chk("rd_s0pc", slot0_pc_o, 64'h24);

        step(2'd3, 1'b0, '0);
        chk("ovr_cnt", 64'(q_count_o), 64'd2);
        chk("ovr_s0pc", slot0_pc_o, 64'h2C);
        chk("ovr_s1pc", slot1_pc_o, 64'h30);

        step(2'd0, 1'b0, '0);
        chk("pre_rst_cnt", 64'(q_count_o), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(q_count_o), 64'd0);
        chk("arst_s0v", 64'(slot0_valid_o), 64'd0);
        chk("arst_s1v", 64'(slot1_valid_o), 64'd0);
        chk("arst_pc", pc_o, RESET_PC);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rel_pc", pc_o, RESET_PC);

        for (int i = 0; i < 20; i++)
            step(2'($urandom_range(0, 3)), 1'b0, '0);

        step(2'd0, 1'b0, '0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
